crc32_checker: RTL and testbench

//  Receive-side counterpart of the bit-serial CRC-32 generator. Accepts one codeword
//  {data, crc} in parallel and divides it bit-serially, MSB first, by the CRC-32 polynomial.

---
 rtl/crc32_checker.sv | 113 +++++++++++
 tb/tb_crc32_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/crc32_checker.sv
// Bit-serial CRC-32 checker: divides one {data, crc} codeword MSB first by POLY
// and reports the remainder, a pass flag, the data field and a saturating error count.
module crc32_checker #(
  parameter int          DATA_W = 5,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter int          CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W+31:0]   codeword,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic [31:0]          syndrome,
  output logic                 crc_ok,
  output logic [CNT_W-1:0]     err_count,
  output logic [1:0]           o_dbg_state
);

  localparam int CW_W  = DATA_W + 32;
  localparam int BIT_W = $clog2(CW_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CW_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW_W-1:0]    r_shreg;
  logic [31:0]        r_rem;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_data_lat;
  logic [DATA_W-1:0]  r_data_out;
  logic [31:0]        r_syndrome;
  logic               r_crc_ok;
  logic [CNT_W-1:0]   r_err_count;

  logic [31:0]        w_rem_next;
  logic               w_accept;
  logic               w_enter_done;

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // Input side accepts only in IDLE; the result is held in DONE until out_ready.
  assign w_accept     = (r_state == IDLE) && in_valid;
  assign w_enter_done = (r_state == SHIFT) && (r_bit_cnt == LAST_BIT);
  assign w_rem_next   = {r_rem[30:0], r_shreg[CW_W-1]} ^ (r_rem[31] ? POLY : 32'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = SHIFT;
      SHIFT:   if (r_bit_cnt == LAST_BIT) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg     <= '0;
      r_rem       <= '0;
      r_bit_cnt   <= '0;
      r_data_lat  <= '0;
      r_data_out  <= '0;
      r_syndrome  <= '0;
      r_crc_ok    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_shreg    <= codeword;
        r_rem      <= '0;
        r_bit_cnt  <= '0;
        r_data_lat <= codeword[CW_W-1:32];
      end
      if (r_state == SHIFT) begin
        r_shreg   <= {r_shreg[CW_W-2:0], 1'b0};
        r_rem     <= w_rem_next;
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
      // Results are captured on the same edge that shifts in the final bit.
      if (w_enter_done) begin
        r_syndrome <= w_rem_next;
        r_crc_ok   <= (w_rem_next == 32'h0);
        r_data_out <= r_data_lat;
        if ((w_rem_next != 32'h0) && (r_err_count != {CNT_W{1'b1}})) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end
    end
  end

  assign in_ready    = (r_state == IDLE) && !rst;
  assign out_valid   = (r_state == DONE);
  assign data_out    = r_data_out;
  assign syndrome    = r_syndrome;
  assign crc_ok      = r_crc_ok;
  assign err_count   = r_err_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_crc32_checker.sv
// Directed bench for crc32_checker: reference codewords, single-bit errors, stall,
// mid-shift reset, throughput and counter saturation on a CNT_W=2 instance.
module tb_crc32_checker;

  localparam logic [36:0] GOOD_CW = {5'b11001, 32'h6ED82B7F};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, crc_ok;
  logic [36:0] codeword;
  logic [4:0]  data_out;
  logic [31:0] syndrome;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, crc_ok2;
  logic [36:0] codeword2;
  logic [4:0]  data_out2;
  logic [31:0] syndrome2;
  logic [1:0]  err_count2;
  logic [1:0]  dbg_state2;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  crc32_checker #(.DATA_W(5), .POLY(32'h04C11DB7), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .crc_ok(crc_ok),
    .err_count(err_count), .o_dbg_state(dbg_state)
  );

  crc32_checker #(.DATA_W(5), .POLY(32'h04C11DB7), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .codeword(codeword2), .out_valid(out_valid2), .out_ready(out_ready2),
    .data_out(data_out2), .syndrome(syndrome2), .crc_ok(crc_ok2),
    .err_count(err_count2), .o_dbg_state(dbg_state2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one codeword, measures latency, and checks the result against the scoreboard.
  task automatic run_cw(input logic [36:0] cw, input logic [31:0] exp_syn,
                        input logic [4:0] exp_data, input logic [15:0] exp_err);
    int n;
    logic [31:0] exp_s;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    check("in_ready_before_send", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    codeword = cw;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(exp_syn);
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check("latency", 64'(n), 64'(37));
    exp_s = exp_q.pop_front();
    check("syndrome", 64'(syndrome), 64'(exp_s));
    check("crc_ok", 64'(crc_ok), 64'(exp_s == 32'h0));
    check("data_out", 64'(data_out), 64'(exp_data));
    check("err_count", 64'(err_count), 64'(exp_err));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_out_valid", 64'(out_valid), 64'(0));
    check("consume_state_idle", 64'(dbg_state), 64'(0));
  endtask

  initial begin
    int n;
    logic [31:0] held_syn;
    logic [1:0]  exp_e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; codeword = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; codeword2 = '0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_syndrome", 64'(syndrome), 64'(0));
    check("rst_crc_ok", 64'(crc_ok), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst = 1'b0;
    tick();

    run_cw(GOOD_CW, 32'h0, 5'b11001, 16'd0);
    consume();
    check("idle_holds_crc_ok", 64'(crc_ok), 64'(1));

    run_cw(GOOD_CW ^ 37'h1, 32'h00000001, 5'b11001, 16'd1);
    consume();
    check("idle_holds_syndrome", 64'(syndrome), 64'(32'h00000001));

    run_cw({5'b11000, 32'h6ED82B7F}, 32'h04C11DB7, 5'b11000, 16'd2);
    consume();

    run_cw({5'b11001, 32'hEED82B7F}, 32'h80000000, 5'b11001, 16'd3);
    consume();

    // Stall in DONE with in_valid pulses that must be ignored.
    run_cw(GOOD_CW, 32'h0, 5'b11001, 16'd3);
    held_syn = syndrome;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      codeword = GOOD_CW ^ 37'(32'h1 << i);
      tick();
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_syndrome", 64'(syndrome), 64'(held_syn));
      check("stall_data_out", 64'(data_out), 64'(5'b11001));
      check("stall_err_count", 64'(err_count), 64'(3));
    end
    in_valid = 1'b0;
    consume();
    tick();
    check("stall_no_pending_accept", 64'(dbg_state), 64'(0));
    check("stall_err_unchanged", 64'(err_count), 64'(3));

    // Back-to-back throughput with in_valid and out_ready held high.
    codeword = GOOD_CW;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check("tput_first_latency", 64'(n), 64'(38));
    tick();
    n = 1;
    while (!out_valid && n < 200) begin tick(); n++; end
    check("tput_period", 64'(n), 64'(39));
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("tput_back_idle", 64'(dbg_state), 64'(0));

    // Reset in the middle of shifting abandons the codeword.
    in_valid = 1'b1;
    codeword = GOOD_CW ^ 37'h1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_err_count", 64'(err_count), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    tick();
    check("midrst_in_ready_after", 64'(in_ready), 64'(1));
    run_cw(37'h0, 32'h0, 5'b00000, 16'd0);
    consume();

    // Saturating counter on the CNT_W=2 instance.
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!in_ready2 && n < 200) begin tick(); n++; end
      in_valid2 = 1'b1;
      codeword2 = GOOD_CW ^ 37'h1;
      tick();
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 200) begin tick(); n++; end
      exp_e = (i < 3) ? 2'(i + 1) : 2'd3;
      check("sat_err_count", 64'(err_count2), 64'(exp_e));
      check("sat_syndrome", 64'(syndrome2), 64'(32'h1));
      check("sat_crc_ok", 64'(crc_ok2), 64'(0));
      check("sat_data_out", 64'(data_out2), 64'(5'b11001));
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
      check("sat_state_idle", 64'(dbg_state2), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
